// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: owns the register file's single write port.
// It merges in-order MEM_WB writebacks with out-of-order long-unit (mul/div)
// results. Long results wait in a small FIFO. A pending-write scoreboard
// lets ID stall on RAW/WAW hazards against results that are still outstanding.
//
// Ports:
//   clk, rst                      clock (rising edge); synchronous active-high reset
//   wb_RegWrite/wb_rd/wb_Rd       MEM_WB write request, index, value
//   wb_hold                       MEM_WB must keep its contents this cycle
//   lu_valid/lu_rd/lu_Rd          long-unit result, index, value
//   lu_ready                      FIFO can accept a long-unit result
//   id_long/id_RegWrite/id_rd     ID issue info for scoreboard set / WAW check
//   rs1/rs2                       IF_ID source indices for RAW check
//   hazard_stall                  ID must stall
//   RegWrite/rd/Rd                register file write port (combinational)
//
// Optional: defining WB_PERF_CNT_EN adds two saturating 32-bit counters,
// perf_hold_cnt and perf_hazard_cnt.
module rf_writeback_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned N_REGS     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_Rd,
  output logic              wb_hold,
  input  logic              lu_valid,
  input  logic [4:0]        lu_rd,
  input  logic [DATA_W-1:0] lu_Rd,
  output logic              lu_ready,
  input  logic              id_long,
  input  logic              id_RegWrite,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              hazard_stall,
  output logic              RegWrite,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] Rd
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hold_cnt,
  output logic [31:0]       perf_hazard_cnt
`endif
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] val;
  } lu_entry_t;

  lu_entry_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [N_REGS-1:0] sb;
  logic [N_REGS-1:0] sb_next;

  lu_entry_t head;
  logic      full;
  logic      not_empty;
  logic      wb_req;
  logic      push;
  logic      pop;
  logic      hazard_raw;
  logic      sb_set;

  assign head      = fifo_mem[rd_ptr];
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign not_empty = (count != '0);
  assign wb_req    = wb_RegWrite && (wb_rd != '0);

  // lu_ready depends only on the registered count, so it has no path from the pop decision.
  assign lu_ready = rst | ~full;
  assign push     = ~rst & lu_valid & ~full & (lu_rd != '0);

  // Write-port select: a full FIFO beats MEM_WB; otherwise MEM_WB beats draining.
  always_comb begin
    RegWrite = 1'b0;
    rd       = '0;
    Rd       = '0;
    wb_hold  = 1'b0;
    pop      = 1'b0;
    if (!rst) begin
      if (full) begin
        pop      = 1'b1;
        RegWrite = 1'b1;
        rd       = head.rd;
        Rd       = head.val;
        wb_hold  = wb_req;
      end else if (wb_req) begin
        RegWrite = 1'b1;
        rd       = wb_rd;
        Rd       = wb_Rd;
      end else if (not_empty) begin
        pop      = 1'b1;
        RegWrite = 1'b1;
        rd       = head.rd;
        Rd       = head.val;
      end
    end
  end

  // Hazard check covers RAW (rs1/rs2) and WAW (id_rd) against pending long results.
  assign hazard_raw   = sb[rs1] | sb[rs2] | (id_RegWrite & sb[id_rd]);
  assign hazard_stall = ~rst & hazard_raw;
  assign sb_set       = id_long & ~hazard_raw & (id_rd != '0);

  // The clear is applied first so that a set of the same index wins.
  always_comb begin
    sb_next = sb;
    if (pop) sb_next[head.rd] = 1'b0;
    if (sb_set) sb_next[id_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // FIFO storage is not reset; the reset count and pointers make stale data unreachable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rd: lu_rd, val: lu_Rd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sb     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      sb <= sb_next;
    end
  end

`ifdef WB_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hold_cnt   <= '0;
      perf_hazard_cnt <= '0;
    end else begin
      if (wb_hold && (perf_hold_cnt != '1))
        perf_hold_cnt <= perf_hold_cnt + 32'd1;
      if (hazard_stall && (perf_hazard_cnt != '1))
        perf_hazard_cnt <= perf_hazard_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter. Expected register-file writes go
// into a queue in commit order, and a negedge monitor pops the queue and compares
// each write against it. Each scenario task also checks control outputs inline.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_Rd;
  logic        wb_hold;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_Rd;
  logic        lu_ready;
  logic        id_long;
  logic        id_RegWrite;
  logic [4:0]  id_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard_stall;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] Rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  rf_writeback_arbiter #(.DATA_W(32), .FIFO_DEPTH(4), .N_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_Rd(wb_Rd), .wb_hold(wb_hold),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_Rd(lu_Rd), .lu_ready(lu_ready),
    .id_long(id_long), .id_RegWrite(id_RegWrite), .id_rd(id_rd),
    .rs1(rs1), .rs2(rs2), .hazard_stall(hazard_stall),
    .RegWrite(RegWrite), .rd(rd), .Rd(Rd)
  );

  always #5 clk = ~clk;

  // Every RF write must match the oldest expected write.
  always @(negedge clk) begin
    if (RegWrite !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: got RegWrite=%b rd=%0d Rd=%h, expected no write", RegWrite, rd, Rd);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd !== mon_e.rd || Rd !== mon_e.val) begin
          errors++;
          $display("FAIL rf_write: got rd=%0d Rd=%h, expected rd=%0d Rd=%h", rd, Rd, mon_e.rd, mon_e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_RegWrite = 1'b0; wb_rd = '0; wb_Rd = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_Rd = '0;
    id_long = 1'b0; id_RegWrite = 1'b0; id_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic exp_write(input logic [4:0] r, input logic [31:0] v);
    wr_t e;
    e.rd = r;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_Rd = 32'hA5;
    id_long = 1'b1; id_rd = 5'd4; rs1 = 5'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (RegWrite !== 1'b0 || rd !== 5'd0 || Rd !== 32'd0 || wb_hold !== 1'b0 ||
          hazard_stall !== 1'b0 || lu_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_outputs: got RegWrite=%b rd=%0d Rd=%h wb_hold=%b hazard=%b lu_ready=%b, expected 0 0 0 0 0 1",
                 RegWrite, rd, Rd, wb_hold, hazard_stall, lu_ready);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    rs1 = 5'd4;
    @(negedge clk);
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_sb: got hazard_stall=%b, expected 0", hazard_stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_wb_write();
    wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_Rd = 32'hA5;
    exp_write(5'd5, 32'hA5);
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b1 || wb_hold !== 1'b0) begin
      errors++;
      $display("FAIL wb_write: got RegWrite=%b wb_hold=%b, expected 1 0", RegWrite, wb_hold);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_long_hazard();
    id_long = 1'b1; id_RegWrite = 1'b1; id_rd = 5'd7;
    @(negedge clk);
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL long_issue: got hazard_stall=%b, expected 0", hazard_stall);
    end
    tick();
    idle_inputs();
    rs1 = 5'd7;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_Rd = 32'h1234;
    @(negedge clk);
    checks++;
    if (hazard_stall !== 1'b1 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall: got hazard_stall=%b RegWrite=%b, expected 1 0", hazard_stall, RegWrite);
    end
    tick();
    lu_valid = 1'b0; lu_rd = '0; lu_Rd = '0;
    exp_write(5'd7, 32'h1234);
    @(negedge clk);
    checks++;
    if (hazard_stall !== 1'b1 || RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL drain_stall: got hazard_stall=%b RegWrite=%b, expected 1 1", hazard_stall, RegWrite);
    end
    tick();
    rs1 = '0; rs2 = 5'd7; id_RegWrite = 1'b1; id_rd = 5'd7;
    @(negedge clk);
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got hazard_stall=%b, expected 0", hazard_stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_wb_priority();
    lu_valid = 1'b1; lu_rd = 5'd9; lu_Rd = 32'h99;
    tick();
    idle_inputs();
    wb_RegWrite = 1'b1; wb_rd = 5'd3; wb_Rd = 32'h33;
    exp_write(5'd3, 32'h33);
    @(negedge clk);
    checks++;
    if (wb_hold !== 1'b0 || rd !== 5'd3) begin
      errors++;
      $display("FAIL wb_priority: got wb_hold=%b rd=%0d, expected 0 3", wb_hold, rd);
    end
    tick();
    idle_inputs();
    exp_write(5'd9, 32'h99);
    tick();
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_empty_after_drain: got RegWrite=%b lu_ready=%b, expected 0 1", RegWrite, lu_ready);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_Rd = 32'hB000 + 32'(i);
      wb_RegWrite = 1'b1; wb_rd = 5'(20 + i); wb_Rd = 32'hC000 + 32'(i);
      exp_write(5'(20 + i), 32'hC000 + 32'(i));
      @(negedge clk);
      checks++;
      if (lu_ready !== 1'b1 || wb_hold !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: got lu_ready=%b wb_hold=%b, expected 1 0", i, lu_ready, wb_hold);
      end
      tick();
    end
    lu_valid = 1'b1; lu_rd = 5'd14; lu_Rd = 32'hDEAD;
    wb_RegWrite = 1'b1; wb_rd = 5'd24; wb_Rd = 32'hC004;
    exp_write(5'd10, 32'hB000);
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b0 || wb_hold !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: got lu_ready=%b wb_hold=%b, expected 0 1", lu_ready, wb_hold);
    end
    tick();
    lu_valid = 1'b0; lu_rd = '0; lu_Rd = '0;
    exp_write(5'd24, 32'hC004);
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1 || wb_hold !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got lu_ready=%b wb_hold=%b, expected 1 0", lu_ready, wb_hold);
    end
    tick();
    idle_inputs();
    for (int i = 1; i < 4; i++) begin
      exp_write(5'(10 + i), 32'hB000 + 32'(i));
      tick();
    end
    tick();
  endtask

  task automatic test_zero_index();
    wb_RegWrite = 1'b1; wb_rd = 5'd0; wb_Rd = 32'hFFFF;
    lu_valid = 1'b1; lu_rd = 5'd0; lu_Rd = 32'hEEEE;
    id_long = 1'b1; id_rd = 5'd0;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0 || wb_hold !== 1'b0 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_wb: got RegWrite=%b wb_hold=%b lu_ready=%b, expected 0 0 1", RegWrite, wb_hold, lu_ready);
    end
    tick();
    idle_inputs();
    id_RegWrite = 1'b1;
    @(negedge clk);
    checks++;
    if (hazard_stall !== 1'b0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL zero_sb: got hazard_stall=%b RegWrite=%b, expected 0 0", hazard_stall, RegWrite);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    id_long = 1'b1; id_rd = 5'd4;
    tick();
    idle_inputs();
    id_long = 1'b1; id_rd = 5'd6;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_Rd = 32'h44;
    wb_RegWrite = 1'b1; wb_rd = 5'd1; wb_Rd = 32'h11;
    exp_write(5'd1, 32'h11);
    tick();
    idle_inputs();
    lu_valid = 1'b1; lu_rd = 5'd6; lu_Rd = 32'h66;
    wb_RegWrite = 1'b1; wb_rd = 5'd2; wb_Rd = 32'h22;
    exp_write(5'd2, 32'h22);
    rs1 = 5'd4; rs2 = 5'd6;
    @(negedge clk);
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL pending_4_6: got hazard_stall=%b, expected 1", hazard_stall);
    end
    tick();
    idle_inputs();
    rst = 1'b1;
    rs1 = 5'd4;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0 || lu_ready !== 1'b1 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got RegWrite=%b lu_ready=%b hazard=%b, expected 0 1 0", RegWrite, lu_ready, hazard_stall);
    end
    tick();
    rst = 1'b0;
    rs1 = 5'd4; rs2 = 5'd6;
    @(negedge clk);
    checks++;
    if (hazard_stall !== 1'b0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got hazard_stall=%b RegWrite=%b, expected 0 0", hazard_stall, RegWrite);
    end
    for (int i = 0; i < 6; i++) tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_wb_write();
    test_long_hazard();
    test_wb_priority();
    test_fifo_full();
    test_zero_index();
    test_reset_mid();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d expected writes not seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
